// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit with wait states, lane select and fault flags
module mem_access_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        done,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        illegal
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt;
    logic          is_store;
    logic [2:0]    f3;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   mem [DEPTH];
    logic          accept, ill, mis, fault;
    logic [1:0]    lane, size;
    logic [AW-1:0] idx;
    logic [31:0]   word, load_val, store_val;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [3:0]    be;

    assign accept = req && state == IDLE && (mem_read || mem_write);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE   ? (accept ? (WAIT_CYCLES > 0 ? WAIT : ACCESS) : IDLE) :
                  state == WAIT   ? (cnt == 4'd0 ? ACCESS : WAIT) : IDLE;
    end

    always_comb begin
        ready = state == IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= '0;
        else if (accept)        cnt <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : '0;
        else if (state == WAIT) cnt <= cnt - 4'd1;
    end

    // Inputs are only meaningful at acceptance; everything downstream uses the latched copy.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_store <= mem_write;
            f3       <= funct3;
            addr     <= alu_result[AW+1:0];
            wdata    <= write_data;
        end
    end

    assign idx   = addr[AW+1:2];
    assign lane  = addr[1:0];
    assign size  = f3[1:0];
    assign ill   = is_store ? f3 > 3'd2 : (f3 == 3'b011 || f3[2:1] == 2'b11);
    assign mis   = !ill && ((size == 2'd1 && lane[0]) || (size == 2'd2 && lane != 2'd0));
    assign fault = ill || mis;

    assign word      = mem[idx];
    assign byte_sel  = word[{lane, 3'b000} +: 8];
    assign half_sel  = lane[1] ? word[31:16] : word[15:0];
    assign load_val  = size == 2'd0 ? {{24{~f3[2] & byte_sel[7]}}, byte_sel} :
                       size == 2'd1 ? {{16{~f3[2] & half_sel[15]}}, half_sel} : word;
    assign be        = size == 2'd0 ? 4'b0001 << lane :
                       size == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign store_val = size == 2'd0 ? {4{wdata[7:0]}} :
                       size == 2'd1 ? {2{wdata[15:0]}} : wdata;

    always_ff @(posedge clk) begin
        if (state == ACCESS && is_store && !fault)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= store_val[8*b +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            read_data  <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            done <= state == ACCESS;
            if (state == ACCESS) begin
                misaligned <= mis;
                illegal    <= ill;
                if (!is_store) read_data <= fault ? '0 : load_val;
            end
        end
    end
endmodule
